// File: rtl/param_fifo_sram.sv
// First-word-fall-through FIFO on an inferred register file, with occupancy
// count, programmable almost-full/almost-empty thresholds and sticky error flags.
module param_fifo_sram #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              write,
    input  logic              read,
    input  logic              clr_flags,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              ovf_q;
    logic              unf_q;
    logic              wr_ok;
    logic              rd_ok;
    logic              ovf_set;
    logic              unf_set;

    // Status is decoded from the count register only, so no input reaches an output.
    assign ready        = (cnt != '0);
    assign full         = (cnt == DEPTH_C);
    assign almost_full  = (cnt >= AFULL_C);
    assign almost_empty = (cnt <= AEMPTY_C);
    assign count        = cnt;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign data_out     = mem[rd_ptr];

    // A write into a full FIFO is still accepted when a read frees a slot this edge.
    assign rd_ok   = read & ready;
    assign wr_ok   = write & (~full | rd_ok);
    assign ovf_set = write & full & ~rd_ok;
    assign unf_set = read & ~ready;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok)
                cnt <= cnt + 1'b1;
            else if (rd_ok && !wr_ok)
                cnt <= cnt - 1'b1;
            // A new error in the same cycle as clr_flags keeps the flag set.
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (clr_flags)
                ovf_q <= 1'b0;
            if (unf_set)
                unf_q <= 1'b1;
            else if (clr_flags)
                unf_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_param_fifo_sram.sv
// Bench for param_fifo_sram: directed scenarios then random traffic, all
// compared against a queue-based model of the FIFO.
module tb_param_fifo_sram;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic       clr_flags = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       ready;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    param_fifo_sram #(.DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
        .clk(clk), .clrn(clrn), .write(write), .read(read), .clr_flags(clr_flags),
        .data_in(data_in), .data_out(data_out), .ready(ready), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("ready", 32'(ready), 32'(n != 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(n >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        if (n != 0)
            chk("data_out", 32'(data_out), 32'(q[0]));
    endtask

    // Drive one cycle of inputs from a negedge, advance the model, check at the next negedge.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic clr);
        logic was_full, was_empty, r_acc, w_acc;
        write = w; read = r; data_in = d; clr_flags = clr;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        r_acc = r && !was_empty;
        w_acc = w && (!was_full || r_acc);
        @(posedge clk);
        if (r_acc) void'(q.pop_front());
        if (w_acc) q.push_back(d);
        if (w && was_full && !r_acc) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (r && was_empty) m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
        @(negedge clk);
        write = 1'b0; read = 1'b0; clr_flags = 1'b0;
        check_all();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_all();
        clrn = 1'b1;
        @(negedge clk);
        check_all();

        // Fill with 0x11..0x88, then drain in order
        for (int i = 1; i <= 8; i++) step(1, 0, 8'(i * 8'h11), 0);
        // Overflow on full, contents intact, then clear
        step(1, 0, 8'h99, 0);
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);

        // Underflow on empty with simultaneous write
        step(0, 1, 8'h00, 0);
        step(1, 1, 8'h5A, 1);
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h00, 0);

        // Full with simultaneous read+write, pointer wrap, sweep 0->8->0
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'hA0 + i), 0);
        step(1, 1, 8'hC3, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);

        // Async reset in the middle of a cycle
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h30 + i), 0);
        step(1, 0, 8'h77, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h30 + i), 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i), 0);
        #2 clrn = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_all();
        @(negedge clk);
        clrn = 1'b1;
        check_all();
        step(1, 0, 8'h42, 0);
        chk("head_after_reset", 32'(data_out), 32'h42);

        // Random traffic with phases biased toward filling and draining
        for (int p = 0; p < 8; p++) begin
            int wp;
            wp = (p % 2 == 0) ? 80 : 20;
            for (int i = 0; i < 60; i++) begin
                logic w, r, c;
                w = ($urandom_range(0, 99) < wp);
                r = ($urandom_range(0, 99) < (100 - wp));
                c = ($urandom_range(0, 99) < 10);
                step(w, r, 8'($urandom), c);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
